counter_ctrl: RTL and testbench

- Control stage that sits directly upstream of the team's WIDTH-bit overflow counter.
- Generates the counter's ena pulse train from a prescaler.
- Consumes the counter's overflow and overflow_err flags and returns clr_overflow and reinit pulses to service or recover it.
- Keeps a saturating overflow-event count and a software-requested snapshot of the counter value.

---
 rtl/counter_ctrl.sv | 130 +++++++++++++
 tb/tb_counter_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Prescaled ena generator plus overflow/error service FSM for the WIDTH-bit overflow counter.
// All outputs registered (one cycle after their cause); no backpressure, pulses are fire-and-forget.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4,
  parameter int PW       = 8,
  parameter int ERR_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             auto_clr,
  input  logic             sw_clr,
  input  logic             cap_req,
  input  logic [WIDTH-1:0] value,
  input  logic             overflow,
  input  logic             overflow_err,
  output logic             ena,
  output logic             clr_overflow,
  output logic             reinit,
  output logic [7:0]       ovf_count,
  output logic             err_flag,
  output logic [WIDTH-1:0] cap_value,
  output logic             cap_valid,
  output logic [1:0]       state_o
);

  localparam int HW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HOLD   = 2'b10,
    REINIT = 2'b11
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [HW-1:0]    hold_q;
  logic             ovf_dly_q;
  logic             ena_q;
  logic             clr_q;
  logic             reinit_q;
  logic [7:0]       ovf_cnt_q;
  logic             err_q;
  logic [WIDTH-1:0] cap_value_q;
  logic             cap_valid_q;

  logic ovf_rise_d;
  assign ovf_rise_d = overflow & ~ovf_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      hold_q      <= '0;
      ovf_dly_q   <= 1'b0;
      ena_q       <= 1'b0;
      clr_q       <= 1'b0;
      reinit_q    <= 1'b0;
      ovf_cnt_q   <= '0;
      err_q       <= 1'b0;
      cap_value_q <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      ena_q       <= 1'b0;
      clr_q       <= 1'b0;
      reinit_q    <= 1'b0;
      cap_valid_q <= cap_req;
      if (cap_req) cap_value_q <= value;

      case (state_q)
        IDLE, RUN: begin
          ovf_dly_q <= overflow;
          if (ovf_rise_d && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
          // An error entry outranks run and every clear request.
          if (overflow_err) begin
            state_q <= HOLD;
            err_q   <= 1'b1;
            presc_q <= '0;
            hold_q  <= '0;
          end else begin
            clr_q <= (ovf_rise_d & auto_clr) | (sw_clr & overflow);
            if (sw_clr) err_q <= 1'b0;
            if (run) begin
              state_q <= RUN;
              if (state_q == RUN) begin
                if (presc_q == PW'(PRESCALE - 1)) begin
                  presc_q <= '0;
                  ena_q   <= 1'b1;
                end else begin
                  presc_q <= presc_q + PW'(1);
                end
              end
            end else begin
              state_q <= IDLE;
              presc_q <= '0;
            end
          end
        end
        HOLD: begin
          ovf_dly_q <= overflow;
          if (hold_q == HW'(ERR_HOLD - 1)) begin
            state_q  <= REINIT;
            reinit_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        REINIT: begin
          presc_q   <= '0;
          hold_q    <= '0;
          ovf_dly_q <= 1'b0;
          state_q   <= run ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ena          = ena_q;
  assign clr_overflow = clr_q;
  assign reinit       = reinit_q;
  assign ovf_count    = ovf_cnt_q;
  assign err_flag     = err_q;
  assign cap_value    = cap_value_q;
  assign cap_valid    = cap_valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural overflow counter closes the loop; expected events queued then matched.
module tb_counter_ctrl;

  localparam int PRESCALE = 4;
  localparam int ERR_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0, auto_clr = 1'b0, sw_clr = 1'b0, cap_req = 1'b0;
  logic [7:0] d_value = 8'h00;
  logic       d_ovf = 1'b0, d_err = 1'b0;
  logic       model_en = 1'b0;

  logic [7:0] m_cnt;
  logic       m_ovf, m_err;

  logic [7:0] value;
  logic       overflow, overflow_err;
  assign value        = model_en ? m_cnt : d_value;
  assign overflow     = model_en ? m_ovf : d_ovf;
  assign overflow_err = model_en ? m_err : d_err;

  logic       ena, clr_overflow, reinit, err_flag, cap_valid;
  logic [7:0] ovf_count, cap_value;
  logic [1:0] state_o;

  counter_ctrl #(.WIDTH(8), .PRESCALE(PRESCALE), .PW(8), .ERR_HOLD(ERR_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .auto_clr(auto_clr), .sw_clr(sw_clr),
    .cap_req(cap_req), .value(value), .overflow(overflow), .overflow_err(overflow_err),
    .ena(ena), .clr_overflow(clr_overflow), .reinit(reinit), .ovf_count(ovf_count),
    .err_flag(err_flag), .cap_value(cap_value), .cap_valid(cap_valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural WIDTH-bit overflow counter driven by the DUT's pulses.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || reinit) begin
      m_cnt <= 8'h00; m_ovf <= 1'b0; m_err <= 1'b0;
    end else begin
      if (clr_overflow) m_ovf <= 1'b0;
      if (ena) begin
        m_cnt <= m_cnt + 8'd1;
        if (m_cnt == 8'hFF) begin
          if (m_ovf && !clr_overflow) m_err <= 1'b1;
          else m_ovf <= 1'b1;
        end
      end
    end
  end

  typedef struct { logic [7:0] v; int t; } cap_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_q[$];
  int   ena_q[$];
  cap_t cap_q[$];

  task automatic tick;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; run = 0; auto_clr = 0; sw_clr = 0; cap_req = 0;
    d_value = 0; d_ovf = 0; d_err = 0; model_en = 0;
    exp_q.delete(); ena_q.delete(); cap_q.delete();
    #13; reset_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b expected 00", state_o); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got %0d expected 0", ovf_count); end
    checks++;
    if ({ena, clr_overflow, reinit, err_flag, cap_valid, cap_value} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {ena, clr_overflow, reinit, err_flag, cap_valid, cap_value});
    end
    #7; reset_n = 1'b1;
    tick; tick;
    checks++; if (state_o !== 2'b00 || ena !== 1'b0) begin errors++; $display("FAIL idle_after_reset got state %b ena %b expected 00 0", state_o, ena); end
  endtask

  task automatic test_prescale;
    int e;
    do_reset;
    run = 1'b1;
    tick;
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL run_entry got %b expected 01", state_o); end
    ena_q = {PRESCALE, 2*PRESCALE, 3*PRESCALE};
    for (int t = 1; t <= 24; t++) begin
      tick;
      if (ena) begin
        checks++;
        if (ena_q.size() == 0) begin errors++; $display("FAIL prescale_extra_ena got cycle %0d expected none", t); end
        else begin
          e = ena_q.pop_front();
          if (t != e) begin errors++; $display("FAIL prescale_ena_time got %0d expected %0d", t, e); end
        end
      end
      if (t == 3*PRESCALE) run = 1'b0;
    end
    checks++; if (ena_q.size() != 0) begin errors++; $display("FAIL prescale_missing_ena got %0d left expected 0", ena_q.size()); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL run_exit got %b expected 00", state_o); end
  endtask

  task automatic test_auto_clr;
    int enas = 0;
    int t_ovf = -1;
    int e;
    do_reset;
    model_en = 1'b1; auto_clr = 1'b1; run = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      tick;
      if (ena) enas++;
      if (m_ovf && t_ovf < 0) begin
        t_ovf = cyc;
        exp_q.push_back(cyc + 1);
        checks++; if (enas != 256) begin errors++; $display("FAIL enas_to_overflow got %0d expected 256", enas); end
      end
      if (clr_overflow) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL auto_clr_extra got cycle %0d expected none", cyc); end
        else begin
          e = exp_q.pop_front();
          if (cyc != e) begin errors++; $display("FAIL auto_clr_time got %0d expected %0d", cyc, e); end
        end
      end
      if (t_ovf >= 0 && cyc == t_ovf + 20) break;
    end
    checks++; if (t_ovf < 0) begin errors++; $display("FAIL auto_clr_timeout got no overflow expected one"); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL auto_clr_missing got %0d left expected 0", exp_q.size()); end
    checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL auto_clr_ovf_count got %0d expected 1", ovf_count); end
    checks++; if (m_ovf !== 1'b0 || err_flag !== 1'b0) begin errors++; $display("FAIL auto_clr_cleared got ovf %b err %b expected 0 0", m_ovf, err_flag); end
    run = 1'b0;
  endtask

  task automatic test_error_recovery;
    int t_e = -1;
    int e;
    do_reset;
    model_en = 1'b1; auto_clr = 1'b0; run = 1'b1;
    for (int k = 0; k < 2200; k++) begin
      tick;
      if (m_err) begin t_e = cyc; break; end
    end
    checks++;
    if (t_e < 0) begin errors++; $display("FAIL err_timeout got no overflow_err expected one"); return; end
    exp_q.push_back(t_e + ERR_HOLD + 1);
    ena_q.push_back(t_e + ERR_HOLD + 2 + PRESCALE);
    ena_q.push_back(t_e + ERR_HOLD + 2 + 2*PRESCALE);
    for (int k = 1; k <= ERR_HOLD + 2 + 2*PRESCALE + 1; k++) begin
      tick;
      if (k == 1) begin
        checks++; if (state_o !== 2'b10 || err_flag !== 1'b1) begin errors++; $display("FAIL hold_entry got state %b err %b expected 10 1", state_o, err_flag); end
        checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL err_ovf_count got %0d expected 1", ovf_count); end
      end
      if (k == 5) sw_clr = 1'b1;
      if (k == 6) sw_clr = 1'b0;
      if (k == 10) begin
        checks++; if (state_o !== 2'b10 || err_flag !== 1'b1) begin errors++; $display("FAIL hold_sw_clr got state %b err %b expected 10 1", state_o, err_flag); end
      end
      if (k == ERR_HOLD + 2) begin
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL reinit_to_run got %b expected 01", state_o); end
      end
      if (reinit) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL reinit_extra got cycle %0d expected none", cyc); end
        else begin
          e = exp_q.pop_front();
          if (cyc != e || state_o !== 2'b11) begin errors++; $display("FAIL reinit_time got %0d state %b expected %0d 11", cyc, state_o, e); end
        end
      end
      if (ena) begin
        checks++;
        if (ena_q.size() == 0) begin errors++; $display("FAIL recovery_extra_ena got cycle %0d expected none", cyc); end
        else begin
          e = ena_q.pop_front();
          if (cyc != e) begin errors++; $display("FAIL recovery_ena_time got %0d expected %0d", cyc, e); end
        end
      end
      if (clr_overflow) begin
        checks++; errors++; $display("FAIL recovery_clr got pulse at %0d expected none", cyc);
      end
    end
    checks++; if (exp_q.size() != 0 || ena_q.size() != 0) begin errors++; $display("FAIL recovery_missing got %0d/%0d left expected 0/0", exp_q.size(), ena_q.size()); end
    sw_clr = 1'b1; tick; sw_clr = 1'b0; tick;
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL run_sw_clr_err got %b expected 0", err_flag); end
    run = 1'b0;
  endtask

  task automatic test_saturation;
    int exp_cnt;
    int clr_seen = 0;
    int e;
    do_reset;
    for (int i = 0; i < 300; i++) begin
      d_ovf = 1'b1; tick; if (clr_overflow) clr_seen++;
      d_ovf = 1'b0; tick; if (clr_overflow) clr_seen++;
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      if (i == 99 || i == 254 || i == 299) begin
        checks++; if (ovf_count !== exp_cnt[7:0]) begin errors++; $display("FAIL sat_count_%0d got %0d expected %0d", i + 1, ovf_count, exp_cnt); end
      end
    end
    checks++; if (clr_seen != 0) begin errors++; $display("FAIL sat_no_auto got %0d pulses expected 0", clr_seen); end
    for (int pass = 0; pass < 2; pass++) begin
      auto_clr = (pass == 1);
      d_ovf = 1'b1; sw_clr = 1'b1;
      exp_q.push_back(cyc + 1);
      tick; sw_clr = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (clr_overflow) begin
          checks++;
          if (exp_q.size() == 0) begin errors++; $display("FAIL sw_clr_extra_%0d got cycle %0d expected none", pass, cyc); end
          else begin
            e = exp_q.pop_front();
            if (cyc != e) begin errors++; $display("FAIL sw_clr_time_%0d got %0d expected %0d", pass, cyc, e); end
          end
        end
        tick;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sw_clr_missing_%0d got %0d left expected 0", pass, exp_q.size()); end
      d_ovf = 1'b0; tick;
    end
    checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d expected 255", ovf_count); end
  endtask

  task automatic test_capture;
    logic [7:0] vals [8] = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF};
    bit         req  [8] = '{1, 0, 0, 1, 1, 1, 0, 0};
    cap_t c;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      d_value = vals[i]; cap_req = req[i];
      if (req[i]) begin c.v = vals[i]; c.t = cyc + 1; cap_q.push_back(c); end
      tick;
      if (cap_valid) begin
        checks++;
        if (cap_q.size() == 0) begin errors++; $display("FAIL cap_extra got cycle %0d expected none", cyc); end
        else begin
          c = cap_q.pop_front();
          if (cap_value !== c.v || cyc != c.t) begin errors++; $display("FAIL cap_value got %h@%0d expected %h@%0d", cap_value, cyc, c.v, c.t); end
        end
      end
    end
    cap_req = 1'b0;
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL cap_missing got %0d left expected 0", cap_q.size()); end
    checks++; if (cap_value !== 8'h33) begin errors++; $display("FAIL cap_hold got %h expected 33", cap_value); end
  endtask

  task automatic test_hold_capture_reset;
    do_reset;
    d_err = 1'b1; tick; d_err = 1'b0;
    checks++; if (state_o !== 2'b10 || err_flag !== 1'b1) begin errors++; $display("FAIL idle_to_hold got state %b err %b expected 10 1", state_o, err_flag); end
    d_value = 8'h5A; cap_req = 1'b1; run = 1'b1; auto_clr = 1'b1;
    tick; cap_req = 1'b0;
    checks++; if (cap_valid !== 1'b1 || cap_value !== 8'h5A) begin errors++; $display("FAIL hold_capture got %b/%h expected 1/5a", cap_valid, cap_value); end
    for (int k = 2; k <= 7; k++) tick;
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL hold_cycle7 got %b expected 10", state_o); end
    #2; reset_n = 1'b0; #1;
    checks++; if (state_o !== 2'b00 || err_flag !== 1'b0) begin errors++; $display("FAIL async_reset_state got %b err %b expected 00 0", state_o, err_flag); end
    checks++;
    if ({ena, clr_overflow, reinit, cap_valid, cap_value, ovf_count} !== 20'd0) begin
      errors++; $display("FAIL async_reset_outputs got %h expected 0", {ena, clr_overflow, reinit, cap_valid, cap_value, ovf_count});
    end
    run = 1'b0; auto_clr = 1'b0;
    #4; reset_n = 1'b1;
    tick;
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b expected 00", state_o); end
  endtask

  initial begin
    test_reset;
    test_prescale;
    test_auto_clr;
    test_error_recovery;
    test_saturation;
    test_capture;
    test_hold_capture_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
